// File: rtl/sccb_cfg_sequencer.sv
// sccb_cfg_sequencer: plays a {reg_addr,data} table out over SCCB at power-up, then serves runtime register writes.
// Ports: clk/rst_n (async active-low), lut_index/lut_data/lut_size (table read port),
//        req_valid/req_ready/req_addr/req_data (runtime writes), sccb_sclk/sccb_sdat (open-drain bus),
//        config_done (table finished), busy (transaction or delay running), err (sticky entry abort).
// Macro SCCB_RETRY_LIMIT_EN: give up on an entry after MAX_RETRY NACKed attempts; otherwise retry forever.
module sccb_cfg_sequencer #(
    parameter int         CLK_FREQ  = 100_000_000,
    parameter int         SCL_FREQ  = 100_000,
    parameter logic [7:0] DEV_ADDR  = 8'h78,
    parameter int         REG_AW    = 16,
    parameter int         IDX_W     = 9,
    parameter int         MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [IDX_W-1:0]  lut_index,
    input  logic [REG_AW+7:0] lut_data,
    input  logic [IDX_W-1:0]  lut_size,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_AW-1:0] req_addr,
    input  logic [7:0]        req_data,
    output logic              sccb_sclk,
    inout  wire               sccb_sdat,
    output logic              config_done,
    output logic              busy,
    output logic              err
);
    localparam int DIV    = CLK_FREQ / (4 * SCL_FREQ);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MS     = CLK_FREQ / 1000;
    localparam int NBYTES = (REG_AW == 16) ? 4 : 3;

    typedef enum logic [3:0] {IDLE, FETCH, DELAY, START, SHIFT, ACK, STOP, GAP, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [31:0]       frame_q, frame_d;
    logic [1:0]        ph_q, ph_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              nack_q, nack_d;
    logic              src_q, src_d;
    logic              scl_q, scl_d;
    logic              sda_oe_q, sda_oe_d;
    logic              done_q, done_d;
    logic              tick, adv, lut_dly;
    logic [15:0]       lut_addr;
    logic [31:0]       frame_ld;
`ifdef SCCB_RETRY_LIMIT_EN
    logic [7:0]        try_q, try_d;
    logic              err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign tick        = div_q == DIV_W'(DIV - 1);
    assign div_d       = tick ? '0 : div_q + 1'b1;
    assign lut_addr    = 16'(lut_data[REG_AW+7:8]);
    assign lut_dly     = &lut_data[REG_AW+7:8];
    // Whole write shifted MSB first; the 8-bit address layout leaves an unused trailing byte.
    assign frame_ld    = (REG_AW == 16) ? {DEV_ADDR, addr_q, data_q} : {DEV_ADDR, addr_q[7:0], data_q, 8'h00};
    assign lut_index   = idx_q;
    assign req_ready   = state_q == DONE;
    assign busy        = !(state_q == IDLE || state_q == DONE);
    assign config_done = done_q;
    assign sccb_sclk   = scl_q;
    assign sccb_sdat   = sda_oe_q ? 1'b0 : 1'bz;

    // Each bit spans four ticks: SDA is set on phase 0 (SCL low), SCL is high on phases 1-2,
    // ACK is sampled on phase 2 and SCL drops again on phase 3.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        frame_d  = frame_q;
        ph_d     = ph_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        nack_d   = nack_q;
        src_d    = src_q;
        scl_d    = scl_q;
        sda_oe_d = sda_oe_q;
        done_d   = done_q;
        adv      = 1'b0;
`ifdef SCCB_RETRY_LIMIT_EN
        try_d    = try_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = (lut_size == '0) ? DONE : FETCH;
                done_d  = lut_size == '0;
            end
            FETCH: begin
                if (idx_q == lut_size) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    addr_d = lut_addr;
                    data_d = lut_data[7:0];
                    src_d  = 1'b0;
                    if (!lut_dly) begin
                        state_d = START;
                        ph_d    = '0;
                    end else if (lut_data[7:0] == '0) begin
                        adv = 1'b1;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = 32'(lut_data[7:0]) * 32'(MS) - 32'd1;
                    end
                end
            end
            DELAY: begin
                cnt_d = cnt_q - 32'd1;
                adv   = cnt_q == '0;
            end
            START: if (tick) begin
                ph_d     = ph_q + 1'b1;
                sda_oe_d = (ph_q == 2'd1) ? 1'b1 : sda_oe_q;
                if (ph_q == 2'd3) begin
                    scl_d   = 1'b0;
                    frame_d = frame_ld;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: if (tick) begin
                ph_d     = ph_q + 1'b1;
                sda_oe_d = (ph_q == 2'd0) ? ~frame_q[31] : sda_oe_q;
                scl_d    = (ph_q == 2'd1) ? 1'b1 : scl_q;
                if (ph_q == 2'd3) begin
                    scl_d   = 1'b0;
                    frame_d = {frame_q[30:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? ACK : SHIFT;
                end
            end
            ACK: if (tick) begin
                ph_d     = ph_q + 1'b1;
                sda_oe_d = (ph_q == 2'd0) ? 1'b0 : sda_oe_q;
                scl_d    = (ph_q == 2'd1) ? 1'b1 : scl_q;
                nack_d   = (ph_q == 2'd2) ? sccb_sdat : nack_q;
                if (ph_q == 2'd3) begin
                    scl_d   = 1'b0;
                    byte_d  = byte_q + 1'b1;
                    state_d = (nack_q || byte_q == 2'(NBYTES - 1)) ? STOP : SHIFT;
                end
            end
            STOP: if (tick) begin
                ph_d     = ph_q + 1'b1;
                sda_oe_d = (ph_q == 2'd0) ? 1'b1 : (ph_q == 2'd3) ? 1'b0 : sda_oe_q;
                scl_d    = (ph_q == 2'd1) ? 1'b1 : scl_q;
                if (ph_q == 2'd3) begin
                    state_d = GAP;
                    cnt_d   = 32'd7;
                end
            end
            GAP: if (tick) begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == '0) begin
                    if (!nack_q) begin
                        adv = 1'b1;
`ifdef SCCB_RETRY_LIMIT_EN
                    end else if (try_q == 8'(MAX_RETRY - 1)) begin
                        adv   = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        try_d   = try_q + 1'b1;
                        state_d = START;
                        ph_d    = '0;
`else
                    end else begin
                        state_d = START;
                        ph_d    = '0;
`endif
                    end
                end
            end
            DONE: if (req_valid) begin
                addr_d  = 16'(req_addr);
                data_d  = req_data;
                src_d   = 1'b1;
                state_d = START;
                ph_d    = '0;
            end
            default: state_d = IDLE;
        endcase
        // Entry finished (written, skipped or delay elapsed): runtime writes return to DONE, table moves on.
        if (adv) begin
`ifdef SCCB_RETRY_LIMIT_EN
            try_d = '0;
`endif
            if (src_q) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            frame_q  <= '0;
            ph_q     <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            cnt_q    <= '0;
            nack_q   <= 1'b0;
            src_q    <= 1'b0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SCCB_RETRY_LIMIT_EN
            try_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            frame_q  <= frame_d;
            ph_q     <= ph_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            nack_q   <= nack_d;
            src_q    <= src_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
            done_q   <= done_d;
`ifdef SCCB_RETRY_LIMIT_EN
            try_q    <= try_d;
            err_q    <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// tb_sccb_cfg_sequencer: scoreboard bench with a bus-level SCCB slave/monitor and a transaction-level model.
module tb_sccb_cfg_sequencer;
    localparam int CLK_FREQ  = 400_000;
    localparam int SCL_FREQ  = 50_000;
    localparam int MS        = CLK_FREQ / 1000;
    localparam int IDX_W     = 9;
    localparam int MAX_RETRY = 3;
`ifdef SCCB_RETRY_LIMIT_EN
    localparam int LIMIT = MAX_RETRY;
`else
    localparam int LIMIT = 1000;
`endif

    typedef struct { logic [31:0] b; int n; int idx; } txn_t;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic [IDX_W-1:0] lut_index;
    logic [IDX_W-1:0] lut_size = '0;
    logic [23:0]      lut_data;
    logic [23:0]      tbl [16];
    logic             req_valid = 1'b0, req_ready;
    logic [15:0]      req_addr = '0;
    logic [7:0]       req_data = '0;
    logic             sccb_sclk, config_done, busy, err;
    wire              sda;
    logic             slv_drv = 1'b0;

    txn_t exp_q[$];
    int   plan_q[$];
    int   total = 0, bad = 0, exp_err = 0, mon_starts = 0, nb = 0, nbits = 0, pos = 4;
    logic pscl = 1'b1, psda = 1'b1, in_txn = 1'b0, s_now, d_now;
    logic [7:0]  cur = '0;
    logic [31:0] got = '0;

    pullup (sda);
    assign sda      = slv_drv ? 1'b0 : 1'bz;
    assign lut_data = tbl[lut_index[3:0]];

    always #5 clk = ~clk;

    sccb_cfg_sequencer #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ), .DEV_ADDR(8'h78), .REG_AW(16),
                         .IDX_W(IDX_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .lut_index(lut_index), .lut_data(lut_data), .lut_size(lut_size),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
        .sccb_sclk(sccb_sclk), .sccb_sdat(sda), .config_done(config_done), .busy(busy), .err(err));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic check_txn();
        txn_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL txn: unexpected transaction %0d bytes %h, expected none", nb, got);
        end else begin
            e = exp_q.pop_front();
            if (nb != e.n || got != e.b || int'(lut_index) != e.idx) begin
                bad++;
                $display("FAIL txn: got %0d bytes %h idx %0d, expected %0d bytes %h idx %0d",
                         nb, got, lut_index, e.n, e.b, e.idx);
            end
        end
    endtask

    // Bus monitor and ACK/NACK slave; pops the NACK plan at each START, scores at each STOP.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn  = 1'b0;
            slv_drv = 1'b0;
            pscl    = 1'b1;
            psda    = 1'b1;
        end else begin
            s_now = sccb_sclk;
            d_now = sda;
            if (pscl && s_now && psda && !d_now) begin
                in_txn = 1'b1;
                nb     = 0;
                nbits  = 0;
                got    = '0;
                if (plan_q.size() > 0) pos = plan_q.pop_front();
                else pos = 4;
                mon_starts++;
            end else if (in_txn && pscl && s_now && !psda && d_now) begin
                in_txn = 1'b0;
                check_txn();
            end else if (in_txn && !pscl && s_now) begin
                if (nbits < 8) cur = {cur[6:0], d_now};
                nbits++;
                if (nbits == 9) begin
                    if (nb < 4) got[31-8*nb -: 8] = cur;
                    nb++;
                    nbits = 0;
                end
            end else if (in_txn && pscl && !s_now) begin
                slv_drv = (nbits == 8) && (nb != pos);
            end
            pscl = s_now;
            psda = d_now;
        end
    end

    // n NACKed attempts, each cut at a random byte, then the full write unless the retry limit is hit.
    task automatic push_txn(input logic [31:0] full, input int n, input int idx);
        txn_t e;
        int p;
        for (int a = 0; a < ((n < LIMIT) ? n : LIMIT); a++) begin
            p = $urandom_range(0, 3);
            plan_q.push_back(p);
            e.b = full & ~(32'hFFFF_FFFF >> (8 * (p + 1)));
            e.n = p + 1;
            e.idx = idx;
            exp_q.push_back(e);
        end
        if (n >= LIMIT) begin
            exp_err = 1;
        end else begin
            plan_q.push_back(4);
            e.b = full;
            e.n = 4;
            e.idx = idx;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_table(input int size, input bit fill, input bit dly, input int maxn, input int fi, input int fn);
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        plan_q.delete();
        exp_err = 0;
        lut_size = IDX_W'(size);
        if (fill) begin
            for (int i = 0; i < size; i++) begin
                if (dly && i > 0 && $urandom_range(0, 3) == 0) tbl[i] = {16'hFFFF, 8'($urandom_range(0, 1))};
                else tbl[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom)};
            end
        end
        for (int i = 0; i < size; i++) begin
            if (tbl[i][23:8] != 16'hFFFF) begin
                n = (i == fi) ? fn : int'($urandom_range(0, maxn));
                push_txn({8'h78, tbl[i]}, n, i);
            end
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic poke();
        int hits = 0;
        req_addr  = 16'($urandom);
        req_data  = 8'($urandom);
        req_valid = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (req_ready) hits++;
        end
        req_valid = 1'b0;
        chk("ready_before_done", hits, 0);
    endtask

    task automatic finish_table(input int size);
        int k = 0;
        while (!config_done && k < 40000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("config_done", config_done, 1);
        chk("lut_index_done", 32'(lut_index), size);
        chk("busy_done", busy, 0);
        chk("ready_done", req_ready, 1);
        chk("err_done", err, exp_err);
        chk("table_pending", exp_q.size(), 0);
    endtask

    task automatic do_req(input logic [15:0] a, input logic [7:0] d, input int n);
        int k = 0;
        push_txn({8'h78, a, d}, n, int'(lut_size));
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("req_ready_drop", req_ready, 0);
        chk("req_busy", busy, 1);
        while (busy && k < 40000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("req_busy_end", busy, 0);
        chk("req_ready_back", req_ready, 1);
        chk("req_pending", exp_q.size(), 0);
        chk("req_lut_index", 32'(lut_index), 32'(lut_size));
        chk("req_err", err, exp_err);
    endtask

    initial begin
        int k, viol, s0, sz;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scl", sccb_sclk, 1);
        chk("rst_sda", sda, 1);
        chk("rst_index", 32'(lut_index), 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", config_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        start_table(0, 1, 0, 0, -1, 0);
        finish_table(0);

        start_table(3, 1, 0, 0, -1, 0);
        poke();
        finish_table(3);
        do_req(16'h3B00, 8'h83, 0);

        start_table(3, 1, 0, 0, 1, 1);
        finish_table(3);

        tbl[0] = {16'hFFFF, 8'd2};
        tbl[1] = {16'h1234, 8'h56};
        start_table(2, 0, 0, 0, -1, 0);
        s0 = mon_starts;
        k = 0;
        viol = 0;
        while (mon_starts == s0 && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
            if (!busy || !sccb_sclk) viol++;
        end
        chk("delay_quiet", viol, 0);
        chk("delay_length", (k >= 2 * MS && k <= 2 * MS + 20), 1);
        finish_table(2);

        for (int r = 0; r < 4; r++) begin
            sz = $urandom_range(1, 6);
            start_table(sz, 1, 1, 2, -1, 0);
            poke();
            finish_table(sz);
            repeat (2) do_req(16'($urandom), 8'($urandom), $urandom_range(0, 1));
        end

        start_table(3, 1, 0, 0, -1, 0);
        k = 0;
        while (!(in_txn && nb == 1 && nbits >= 3) && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reach_byte2", k < 5000, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_scl", sccb_sclk, 1);
        chk("midrst_sda", sda, 1);
        chk("midrst_index", 32'(lut_index), 0);
        chk("midrst_busy", busy, 0);
        start_table(3, 0, 0, 0, -1, 0);
        finish_table(3);

`ifdef SCCB_RETRY_LIMIT_EN
        start_table(2, 1, 0, 0, 0, MAX_RETRY);
        finish_table(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sccb_cfg_sequencer.md
SCCB_CFG_SEQUENCER -- requirements
Module: sccb_cfg_sequencer

Interface
REQ-001 Parameter CLK_FREQ, 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SCL_FREQ, 100_000, SCL frequency in Hz.
REQ-003 Parameter DEV_ADDR, 8'h78, 8-bit write device address; bit0 = 0.
REQ-004 Parameter REG_AW, 16, register address width; legal values are 8 and 16.
REQ-005 Parameter IDX_W, 9, table index width.
REQ-006 Parameter MAX_RETRY, 3, retry attempts per entry when SCCB_RETRY_LIMIT_EN is defined.
REQ-007 Port clk, input, 1, single system clock; all state is on its rising edge.
REQ-008 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 Port lut_index, output, IDX_W, table entry address.
REQ-010 Port lut_data, input, REG_AW+8, {reg_addr, data}; combinational from lut_index.
REQ-011 Port lut_size, input, IDX_W, number of table entries.
REQ-012 Port req_valid, input, 1, runtime write request.
REQ-013 Port req_ready, output, 1, runtime request accepted.
REQ-014 Port req_addr, input, REG_AW, runtime register address.
REQ-015 Port req_data, input, 8, runtime register data.
REQ-016 Port sccb_sclk, output, 1, SCL.
REQ-017 Port sccb_sdat, inout, 1, SDA; driven low or released (Z), never driven high.
REQ-018 Port config_done, output, 1, table finished.
REQ-019 Port busy, output, 1, transaction or delay in progress.
REQ-020 Port err, output, 1, sticky entry-abort flag.

Function
REQ-021 Quarter-bit tick: one clk pulse every CLK_FREQ/(4*SCL_FREQ) clocks; each SCL bit is 4 ticks; SDA changes only while SCL is low.
REQ-022 Transaction: START, DEV_ADDR, address bytes MSB first (1 byte if REG_AW=8, else 2), data byte, STOP; ACK sampled on tick 2 of each 9th bit; low = ACK.
REQ-023 FSM states: IDLE, FETCH, DELAY, START, SHIFT, ACK, STOP, GAP, DONE.
REQ-024 After reset: lut_index=0, then FETCH; if lut_size=0, go directly to DONE.
REQ-025 FETCH: an entry with reg_addr all ones is a delay entry -> DELAY for data x 1 ms (CLK_FREQ/1000 clocks); data=0 means no delay; no bus activity.
REQ-026 Any NACK -> STOP, then GAP (8 ticks), then the same entry repeats.
REQ-027 Successful entry -> lut_index+1; when lut_index reaches lut_size -> DONE, config_done=1.
REQ-028 DONE: req_ready=1 while idle; req_valid&&req_ready captures req_addr/req_data in one cycle, req_ready drops the next cycle, and the write uses the same NACK/retry rules.
REQ-029 req_valid before DONE is ignored and not queued; req_ready stays 0 until DONE.
REQ-030 busy=1 in every state except IDLE and DONE.
REQ-031 lut_index does not wrap; it holds at lut_size in DONE.

Reset
REQ-032 On rst_n low, asynchronously: sccb_sclk=1, SDA released, lut_index=0, req_ready=0, config_done=0, busy=0, err=0, tick counter 0, FSM IDLE.
REQ-033 Reset mid-transaction abandons the bus without a STOP; after release, the sequence restarts from entry 0.

Configuration
REQ-034 Macro SCCB_RETRY_LIMIT_EN defined: after MAX_RETRY consecutive NACKs on one entry, skip the entry (or drop the runtime request), set err=1, and continue.
REQ-035 Macro SCCB_RETRY_LIMIT_EN undefined: retry without limit; err is tied to 0.

Verification
REQ-036 REG_AW=16, 3-entry table, slave always ACKs -> bytes 78, addr hi, addr lo, data per entry; config_done=1 after entry 2; lut_index=3.
REQ-037 Entry {16'hFFFF, 8'd2} -> no SCL toggles for 2 x CLK_FREQ/1000 clocks; busy=1 throughout.
REQ-038 Slave NACKs the first attempt of entry 1 -> STOP, GAP, entry 1 resent; lut_index stays 1 until ACK.
REQ-039 SCCB_RETRY_LIMIT_EN with MAX_RETRY=3, entry 0 always NACKed -> 3 attempts, err=1, lut_index advances to 1.
REQ-040 After DONE, req_valid with addr 16'h3B00, data 8'h83 -> one req_ready cycle, bytes 78 3B 00 83 on the bus, busy returns to 0.
REQ-041 rst_n asserted during the 2nd byte -> SCL=1, SDA=Z immediately; after release, entry 0 is sent again.
